// File: rtl/traffic_phase_scheduler.sv
// Round-robin green-phase scheduler for a 4-approach junction.
// GREEN -> YELLOW -> ALL_RED clearance, timed in prescaled ticks; lamp outputs are registered.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 3,
  parameter int unsigned MIN_GREEN = 2,
  parameter int unsigned MAX_GREEN = 5,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  traffic,
  output logic [11:0] light,
  output logic [1:0]  grant_idx,
  output logic        grant_valid,
  output logic        phase_start
);

  // state    | meaning
  // S_ALLRED | every approach red; grants the next requester once clearance has elapsed
  // S_GREEN  | approach cur green, all others red
  // S_YELLOW | approach cur yellow, all others red
  localparam logic [1:0] S_ALLRED = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    timer_q, timer_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    last_q, last_d;
  logic          clr_done_q, clr_done_d;
  logic [11:0]   light_q, light_d;
  logic [1:0]    gidx_q, gidx_d;
  logic          gvalid_q, gvalid_d;
  logic          pstart_q, pstart_d;

  logic          tick;
  logic [1:0]    sel;
  logic [3:0]    others;

  function automatic logic thr_met(input logic [7:0] t, input int unsigned thr);
    return ({1'b0, t} + 9'd1) >= 9'(thr);
  endfunction

  assign tick   = (pre_q == PRE_LAST);
  assign others = traffic & ~(4'b0001 << cur_q);

  // Scan downward so the nearest requester after last wins.
  always_comb begin
    sel = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (traffic[2'(last_q + 2'(k))]) sel = 2'(last_q + 2'(k));
    end
  end

  always_comb begin
    pre_d      = tick ? '0 : pre_q + PW'(1);
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    clr_done_d = clr_done_q;
    pstart_d   = 1'b0;

    case (state_q)
      S_ALLRED: begin
        if (clr_done_q || (tick && thr_met(timer_q, ALLRED_T))) begin
          clr_done_d = 1'b1;
          if (|traffic) begin
            state_d  = S_GREEN;
            cur_d    = sel;
            last_d   = sel;
            pstart_d = 1'b1;
          end
        end
      end
      S_GREEN: begin
        if (tick && thr_met(timer_q, MIN_GREEN) &&
            (!traffic[cur_q] || (thr_met(timer_q, MAX_GREEN) && (|others))))
          state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (tick && thr_met(timer_q, YELLOW_T)) begin
          state_d    = S_ALLRED;
          clr_done_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_ALLRED;
        cur_d      = 2'd0;
        clr_done_d = 1'b1;
      end
    endcase

    if (state_d != state_q)
      timer_d = 8'd0;
    else if (tick && (timer_q != 8'hFF))
      timer_d = timer_q + 8'd1;
    else
      timer_d = timer_q;

    gvalid_d = (state_d == S_GREEN) || (state_d == S_YELLOW);
    gidx_d   = gvalid_d ? cur_d : 2'd0;
    light_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (gvalid_d && (cur_d == 2'(i)))
        light_d[3*i +: 3] = (state_d == S_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
      else
        light_d[3*i +: 3] = LAMP_RED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ALLRED;
      pre_q      <= '0;
      timer_q    <= 8'd0;
      cur_q      <= 2'd0;
      last_q     <= 2'd3;
      clr_done_q <= 1'b1;
      light_q    <= 12'b001_001_001_001;
      gidx_q     <= 2'd0;
      gvalid_q   <= 1'b0;
      pstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      timer_q    <= timer_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      clr_done_q <= clr_done_d;
      light_q    <= light_d;
      gidx_q     <= gidx_d;
      gvalid_q   <= gvalid_d;
      pstart_q   <= pstart_d;
    end
  end

  assign light       = light_q;
  assign grant_idx   = gidx_q;
  assign grant_valid = gvalid_q;
  assign phase_start = pstart_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with TICK_DIV=3, MIN_GREEN=2, MAX_GREEN=5, YELLOW_T=3, ALLRED_T=1.
// Cycle k counts negedges after the last reset edge; expected lamp timelines are hand-derived.
module tb_traffic_phase_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  traffic = 4'd0;
  logic [11:0] light;
  logic [1:0]  grant_idx;
  logic        grant_valid;
  logic        phase_start;

  int tests = 0;
  int failed = 0;

  localparam logic [11:0] ALL_RED = 12'b001_001_001_001;

  traffic_phase_scheduler #(
    .TICK_DIV(3), .MIN_GREEN(2), .MAX_GREEN(5), .YELLOW_T(3), .ALLRED_T(1)
  ) dut (
    .clk(clk), .reset(reset), .traffic(traffic), .light(light),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] lamp(input int app, input logic [2:0] v);
    logic [11:0] r;
    r = ALL_RED;
    r[3*app +: 3] = v;
    return r;
  endfunction

  // Leaves the bench at the negedge of cycle 0 with reset low and traffic = t.
  task automatic do_reset(input logic [3:0] t);
    @(negedge clk);
    reset = 1'b1;
    traffic = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    traffic = t;
  endtask

  initial begin
    logic [11:0] e;
    logic        eps;

    // 1: idle after reset
    do_reset(4'b0000);
    chk("rst_light", light, ALL_RED);
    chk("rst_gidx", 12'(grant_idx), 12'd0);
    chk("rst_gvalid", 12'(grant_valid), 12'd0);
    chk("rst_pstart", 12'(phase_start), 12'd0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      chk("idle_light", light, ALL_RED);
      chk("idle_gvalid", 12'(grant_valid), 12'd0);
      chk("idle_pstart", 12'(phase_start), 12'd0);
    end

    // 2 and 3: single requester is granted immediately and held
    do_reset(4'b0001);
    @(negedge clk);
    chk("grant0_light", light, lamp(0, 3'b100));
    chk("grant0_gidx", 12'(grant_idx), 12'd0);
    chk("grant0_gvalid", 12'(grant_valid), 12'd1);
    chk("grant0_pstart", 12'(phase_start), 12'd1);
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      chk("hold0_light", light, lamp(0, 3'b100));
      chk("hold0_pstart", 12'(phase_start), 12'd0);
    end

    // 5: request dropped at first GREEN tick (cycle 2); yellow 6..14, red from 15
    do_reset(4'b0001);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) traffic = 4'b0000;
      if (k <= 5)       e = lamp(0, 3'b100);
      else if (k <= 14) e = lamp(0, 3'b010);
      else              e = ALL_RED;
      chk("drop_light", light, e);
      chk("drop_gvalid", 12'(grant_valid), 12'(k <= 14));
    end

    // 4: contention between approaches 0 and 2
    do_reset(4'b0101);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k <= 14)      e = lamp(0, 3'b100);
      else if (k <= 23) e = lamp(0, 3'b010);
      else if (k <= 26) e = ALL_RED;
      else if (k <= 41) e = lamp(2, 3'b100);
      else if (k <= 50) e = lamp(2, 3'b010);
      else if (k <= 53) e = ALL_RED;
      else              e = lamp(0, 3'b100);
      eps = (k == 1) || (k == 27) || (k == 54);
      chk("rr_light", light, e);
      chk("rr_pstart", 12'(phase_start), 12'(eps));
      if ((k > 26 && k <= 50))
        chk("rr_gidx2", 12'(grant_idx), 12'd2);
      else if (k <= 23 || k >= 54)
        chk("rr_gidx0", 12'(grant_idx), 12'd0);
    end

    // 6: reset during approach 1 yellow, then re-grant
    do_reset(4'b0010);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) traffic = 4'b0000;
      if (k <= 8) e = lamp(1, 3'b100);
      else        e = lamp(1, 3'b010);
      chk("y1_light", light, e);
      if (k == 1) chk("y1_gidx", 12'(grant_idx), 12'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_y_light", light, ALL_RED);
    chk("rst_y_gvalid", 12'(grant_valid), 12'd0);
    reset = 1'b0;
    traffic = 4'b0010;
    @(negedge clk);
    chk("regrant_light", light, lamp(1, 3'b100));
    chk("regrant_gidx", 12'(grant_idx), 12'd1);
    chk("regrant_pstart", 12'(phase_start), 12'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
